approx_add_error_monitor: RTL and testbench
===========================================

# approx_add_error_monitor

Streaming error-statistics engine that sits on the output side of the team's approximate ripple-carry adders (e.g. 16-bit adders with approximate low-order full-adder cells). It accepts operand pairs together with the approximate adder's sum, recomputes the exact sum, and accumulates error statistics over a fixed window of 2^LOG2_WIN samples:

- mean absolute error (MAE)
- worst-case error
- error-occurrence count

These results provide simulation-side evidence alongside the formal delay/MAE characterisation of each adder variant.

## Interface

Parameters:
- WIDTH, 16, operand width; approximate sum is WIDTH+1 bits.
- LOG2_WIN, 8, log2 of samples per window (window N = 2^LOG2_WIN).

Ports:
- clk  in  1  single clock; all logic rising-edge.
- rst_n  in  1  synchronous reset, active-low.
- start  in  1  pulse; clears statistics and opens a window. Honoured in IDLE and DONE only.
- in_valid  in  1  sample valid.
- in_ready  out  1  sample ready.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_approx  in  WIDTH+1  approximate adder output for (in_a, in_b).
- busy  out  1  high in RUN and DRAIN.
- done  out  1  one-cycle pulse when window results become valid.
- mae  out  WIDTH+1  floor(sum of |err| / N).
- max_err  out  WIDTH+1  maximum |err| in window.
- err_cnt  out  LOG2_WIN+1  number of samples with err != 0.

## Operation

- Per-sample arithmetic:
  - exact = in_a + in_b, computed at WIDTH+1 bits with no truncation.
  - err = in_approx − exact.
  - |err| fits in WIDTH+1 bits.
- Sum accumulator:
  - Width WIDTH+1+LOG2_WIN; it cannot overflow.
  - mae = accumulator >> LOG2_WIN.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE → RUN on start. Clears the accumulator, max, count and accepted-sample counter.
  - RUN: in_ready = 1 while accepted < N. A sample is accepted when in_valid & in_ready. The Nth acceptance moves the FSM to DRAIN at the same edge, and in_ready drops in the following cycle.
  - DRAIN: in_ready = 0. Waits for the 2-stage pipeline to empty, then enters DONE.
  - DONE: done = 1 for exactly one cycle. Next state is IDLE, or RUN if start is high in that cycle.
- Pipeline:
  - Stage 1 registers exact, in_approx and a valid flag at the accept edge.
  - Stage 2 updates the accumulator, max and count at the following edge.
- Output registers:
  - mae, max_err and err_cnt are loaded from the internal state on entry to DONE.
  - They hold until the next DONE entry. start does not clear them.
- start while in RUN or DRAIN is ignored. The window is not restarted.
- in_valid while not ready is not accepted. Its data is not consumed.
- Reset (rst_n = 0 at an edge, in any state) produces:
  - state IDLE
  - all counters, accumulators and pipeline valids = 0
  - in_ready = 0, busy = 0, done = 0
  - mae = 0, max_err = 0, err_cnt = 0
  - A partially accumulated window is discarded.

## Timing

- Nth sample accepted at edge k:
  - stage 1 at k
  - accumulate at k+1
  - DONE entered at k+2
  - done = 1 and new outputs visible in the cycle after edge k+2
- Minimum window latency, start sampled at edge s, no backpressure: first acceptance at s+1, last at s+N, done visible after edge s+N+2.
- in_ready is a registered function of state and the accepted-sample counter. There is no combinational path from in_valid.
- busy = 1 from the cycle after start is accepted until DONE is entered.

## Configuration

- ERRMON_BIAS_EN:
  - Defined: adds output port bias (signed, WIDTH+2+LOG2_WIN bits), the signed sum of err over the window. It is loaded in DONE with the other outputs, reset value 0, and has its own signed accumulator.
  - Undefined: the port and the accumulator are absent; all other behaviour is identical.

## Test plan

- WIDTH=16, LOG2_WIN=8, in_approx = in_a + in_b exactly for 256 random samples → mae=0, max_err=0, err_cnt=0, done single pulse exactly 258 cycles after the start edge.
- One sample with in_approx = exact + 511 (e.g. a=0x00FF, b=0x0100, approx=0x03FE), 255 exact samples → max_err=511, err_cnt=1, mae=1.
- All 256 samples with exact − approx = 256 → mae=256, max_err=256, err_cnt=256. With ERRMON_BIAS_EN: bias = −65536.
- LOG2_WIN=2, in_valid toggling every other cycle → exactly 4 samples accepted; the 5th offered sample remains unaccepted with in_ready=0. start during RUN has no effect.
- rst_n low for one edge in the middle of RUN (after 100 samples), then start plus 256 exact samples → outputs remain 0 through reset, and the new window reports mae=0, err_cnt=0 with no carry-over.
- Back-to-back windows: start held high in the DONE cycle → RUN re-entered immediately. The previous outputs are held until the second done pulse.

Source files
------------

// File: rtl/approx_add_error_monitor_if.sv
// Sample stream into the approximate-adder error monitor: operand pair plus the
// approximate sum, with a valid/ready handshake.
interface approx_add_error_monitor_if #(
   parameter int WIDTH = 16
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_a;
   logic [WIDTH-1:0] in_b;
   logic [WIDTH:0]   in_approx;

   modport master (
      output in_valid,
      output in_a,
      output in_b,
      output in_approx,
      input  in_ready
   );

   modport slave (
      input  in_valid,
      input  in_a,
      input  in_b,
      input  in_approx,
      output in_ready
   );
endinterface

// File: rtl/approx_add_error_monitor.sv
// Windowed error statistics (MAE, worst |err|, error count) for an approximate adder.
// Optional signed error sum on port bias when ERRMON_BIAS_EN is defined.
module approx_add_error_monitor #(
   parameter int WIDTH    = 16,
   parameter int LOG2_WIN = 8
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      start,
   approx_add_error_monitor_if.slave s_if,
   output logic                      busy,
   output logic                      done,
   output logic [WIDTH:0]            mae,
   output logic [WIDTH:0]            max_err,
`ifdef ERRMON_BIAS_EN
   output logic [LOG2_WIN:0]         err_cnt,
   output logic signed [WIDTH+1+LOG2_WIN:0] bias
`else
   output logic [LOG2_WIN:0]         err_cnt
`endif
);

   localparam int AW = WIDTH + 1 + LOG2_WIN;
   localparam int BW = WIDTH + 2 + LOG2_WIN;
   localparam logic [LOG2_WIN:0] LAST_IDX = (LOG2_WIN+1)'((1 << LOG2_WIN) - 1);
   localparam logic [LOG2_WIN:0] CNT_ONE  = {{LOG2_WIN{1'b0}}, 1'b1};

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;
   localparam logic [1:0] ST_DONE  = 2'd3;

   function automatic logic [WIDTH+1:0] signed_err(input logic [WIDTH:0] approx,
                                                    input logic [WIDTH:0] exact);
      return {1'b0, approx} - {1'b0, exact};
   endfunction

   function automatic logic [WIDTH:0] abs_err(input logic [WIDTH+1:0] e);
      logic [WIDTH+1:0] m;
      m = e[WIDTH+1] ? ((~e) + {{(WIDTH+1){1'b0}}, 1'b1}) : e;
      return m[WIDTH:0];
   endfunction

   logic [1:0]       state_q, state_d;
   logic [LOG2_WIN:0] acc_cnt_q, acc_cnt_d;
   logic             in_ready_q, in_ready_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH:0]   s1_exact_q, s1_exact_d;
   logic [WIDTH:0]   s1_approx_q, s1_approx_d;
   logic [AW-1:0]    sum_q, sum_d;
   logic [WIDTH:0]   max_q, max_d;
   logic [LOG2_WIN:0] cnt_q, cnt_d;
   logic [WIDTH:0]   mae_q, mae_d;
   logic [WIDTH:0]   max_err_q, max_err_d;
   logic [LOG2_WIN:0] err_cnt_q, err_cnt_d;
   logic signed [BW-1:0] bias_acc_q, bias_acc_d;
   logic signed [BW-1:0] bias_q, bias_d;

   logic             accept_s;
   logic             open_s;
   logic             load_s;
   logic [WIDTH+1:0] err_s;
   logic [WIDTH:0]   abs_s;

   // Next-state, stage-1 capture, stage-2 accumulation and result load
   always_comb begin
      accept_s = s_if.in_valid & in_ready_q;
      open_s   = start & ((state_q == ST_IDLE) | (state_q == ST_DONE));
      err_s    = signed_err(s1_approx_q, s1_exact_q);
      abs_s    = abs_err(err_s);

      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start) state_d = ST_RUN; else state_d = ST_IDLE;
         ST_RUN:   if (accept_s && (acc_cnt_q == LAST_IDX)) state_d = ST_DRAIN;
                   else state_d = ST_RUN;
         ST_DRAIN: if (!s1_valid_q) state_d = ST_DONE; else state_d = ST_DRAIN;
         ST_DONE:  if (start) state_d = ST_RUN; else state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      acc_cnt_d  = acc_cnt_q;
      sum_d      = sum_q;
      max_d      = max_q;
      cnt_d      = cnt_q;
      bias_acc_d = bias_acc_q;
      if (open_s) begin
         acc_cnt_d  = '0;
         sum_d      = '0;
         max_d      = '0;
         cnt_d      = '0;
         bias_acc_d = '0;
      end else begin
         if (accept_s) acc_cnt_d = acc_cnt_q + CNT_ONE;
         else          acc_cnt_d = acc_cnt_q;
         // The pipeline is always empty when a window opens, so no stage-2 work is lost above.
         if (s1_valid_q) begin
            sum_d      = sum_q + {{LOG2_WIN{1'b0}}, abs_s};
            bias_acc_d = bias_acc_q + $signed({{LOG2_WIN{err_s[WIDTH+1]}}, err_s});
            if (abs_s > max_q) max_d = abs_s; else max_d = max_q;
            if (|err_s) cnt_d = cnt_q + CNT_ONE; else cnt_d = cnt_q;
         end else begin
            sum_d      = sum_q;
            bias_acc_d = bias_acc_q;
            max_d      = max_q;
            cnt_d      = cnt_q;
         end
      end

      s1_valid_d  = accept_s;
      s1_exact_d  = accept_s ? ({1'b0, s_if.in_a} + {1'b0, s_if.in_b}) : s1_exact_q;
      s1_approx_d = accept_s ? s_if.in_approx : s1_approx_q;

      in_ready_d = (state_d == ST_RUN);
      busy_d     = (state_d == ST_RUN) | (state_d == ST_DRAIN);
      done_d     = (state_d == ST_DONE);

      load_s    = (state_q == ST_DRAIN) & (state_d == ST_DONE);
      mae_d     = load_s ? sum_q[AW-1:LOG2_WIN] : mae_q;
      max_err_d = load_s ? max_q : max_err_q;
      err_cnt_d = load_s ? cnt_q : err_cnt_q;
      bias_d    = load_s ? bias_acc_q : bias_q;
   end

   // State and datapath registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         acc_cnt_q   <= '0;
         in_ready_q  <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         s1_valid_q  <= 1'b0;
         s1_exact_q  <= '0;
         s1_approx_q <= '0;
         sum_q       <= '0;
         max_q       <= '0;
         cnt_q       <= '0;
         mae_q       <= '0;
         max_err_q   <= '0;
         err_cnt_q   <= '0;
         bias_acc_q  <= '0;
         bias_q      <= '0;
      end else begin
         state_q     <= state_d;
         acc_cnt_q   <= acc_cnt_d;
         in_ready_q  <= in_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         s1_valid_q  <= s1_valid_d;
         s1_exact_q  <= s1_exact_d;
         s1_approx_q <= s1_approx_d;
         sum_q       <= sum_d;
         max_q       <= max_d;
         cnt_q       <= cnt_d;
         mae_q       <= mae_d;
         max_err_q   <= max_err_d;
         err_cnt_q   <= err_cnt_d;
         bias_acc_q  <= bias_acc_d;
         bias_q      <= bias_d;
      end
   end

   assign s_if.in_ready = in_ready_q;
   assign busy          = busy_q;
   assign done          = done_q;
   assign mae           = mae_q;
   assign max_err       = max_err_q;
   assign err_cnt       = err_cnt_q;
`ifdef ERRMON_BIAS_EN
   assign bias          = bias_q;
`endif

endmodule

// File: tb/tb_approx_add_error_monitor.sv
// Scoreboard bench: a 256-sample window instance and a 4-sample window instance.
// Expected results are pushed at window start and popped on each done pulse.
module tb_approx_add_error_monitor;
   localparam int W = 16;

   typedef struct {
      int     mae;
      int     mx;
      int     cnt;
      longint bias;
      int     lat;
      int     s_cyc;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic start = 1'b0;
   logic start_s = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;
   int   acc_small = 0;
   logic done_prev = 1'b0;
   logic done_s_prev = 1'b0;
   exp_t exp_q[$];
   exp_t exp_s_q[$];

   approx_add_error_monitor_if #(.WIDTH(W)) big_if ();
   approx_add_error_monitor_if #(.WIDTH(W)) small_if ();

   logic       busy, done, busy_s, done_s;
   logic [W:0] mae, max_err, mae_s, max_err_s;
   logic [8:0] err_cnt;
   logic [2:0] err_cnt_s;
`ifdef ERRMON_BIAS_EN
   logic signed [W+9:0] bias;
   logic signed [W+3:0] bias_s;
`endif

   approx_add_error_monitor #(.WIDTH(W), .LOG2_WIN(8)) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start), .s_if(big_if.slave),
      .busy(busy), .done(done), .mae(mae), .max_err(max_err),
`ifdef ERRMON_BIAS_EN
      .err_cnt(err_cnt), .bias(bias)
`else
      .err_cnt(err_cnt)
`endif
   );

   approx_add_error_monitor #(.WIDTH(W), .LOG2_WIN(2)) u_small (
      .clk(clk), .rst_n(rst_n), .start(start_s), .s_if(small_if.slave),
      .busy(busy_s), .done(done_s), .mae(mae_s), .max_err(max_err_s),
`ifdef ERRMON_BIAS_EN
      .err_cnt(err_cnt_s), .bias(bias_s)
`else
      .err_cnt(err_cnt_s)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input longint act, input longint exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   // Big-window monitor: pop and compare on every done pulse
   always @(negedge clk) begin
      if (rst_n && done) begin
         exp_t e;
         chk("done_pulse_width", done_prev, 0);
         if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            e = exp_q.pop_front();
            chk("mae", mae, e.mae);
            chk("max_err", max_err, e.mx);
            chk("err_cnt", err_cnt, e.cnt);
`ifdef ERRMON_BIAS_EN
            chk("bias", bias, e.bias);
`endif
            if (e.lat >= 0) chk("done_latency", cyc - e.s_cyc, e.lat);
         end
      end
      done_prev <= done;
   end

   // Small-window monitor plus acceptance counter
   always @(negedge clk) begin
      if (small_if.in_valid && small_if.in_ready) acc_small <= acc_small + 1;
      if (rst_n && done_s) begin
         exp_t e;
         chk("s_done_pulse_width", done_s_prev, 0);
         if (exp_s_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL s_unexpected_done: got done at cycle %0d expected none", cyc);
         end else begin
            e = exp_s_q.pop_front();
            chk("s_mae", mae_s, e.mae);
            chk("s_max_err", max_err_s, e.mx);
            chk("s_err_cnt", err_cnt_s, e.cnt);
`ifdef ERRMON_BIAS_EN
            chk("s_bias", bias_s, e.bias);
`endif
            if (e.lat >= 0) chk("s_done_latency", cyc - e.s_cyc, e.lat);
         end
      end
      done_s_prev <= done_s;
   end

   task automatic push_exp(input int m, input int mx, input int c, input longint b, input int lat);
      exp_t e;
      e.mae = m; e.mx = mx; e.cnt = c; e.bias = b; e.lat = lat; e.s_cyc = cyc + 1;
      exp_q.push_back(e);
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic send(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W:0] ap);
      logic acc;
      big_if.in_valid = 1'b1;
      big_if.in_a = a;
      big_if.in_b = b;
      big_if.in_approx = ap;
      acc = 1'b0;
      for (int t = 0; t < 50 && !acc; t++) begin
         acc = big_if.in_ready;
         @(posedge clk); #1;
      end
      if (!acc) chk("accept_timeout", acc, 1);
   endtask

   task automatic send_exact();
      logic [W-1:0] a, b;
      a = W'($urandom_range(0, 65535));
      b = W'($urandom_range(0, 65535));
      send(a, b, {1'b0, a} + {1'b0, b});
   endtask

   task automatic wait_drained();
      for (int t = 0; t < 2000 && (exp_q.size() != 0 || exp_s_q.size() != 0); t++)
         @(posedge clk);
      #1;
      chk("drain_timeout", exp_q.size() + exp_s_q.size(), 0);
   endtask

   logic [W-1:0] oa [5];
   logic [W-1:0] ob [5];
   logic [W:0]   oap[5];

   initial begin
      big_if.in_valid = 1'b0; big_if.in_a = '0; big_if.in_b = '0; big_if.in_approx = '0;
      small_if.in_valid = 1'b0; small_if.in_a = '0; small_if.in_b = '0; small_if.in_approx = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_ready", big_if.in_ready, 0);
      chk("rst_mae", mae, 0);
      chk("rst_err_cnt", err_cnt, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;

      // Window 1: exact random samples, latency 258
      push_exp(0, 0, 0, 0, 258);
      pulse_start();
      chk("busy_after_start", busy, 1);
      for (int i = 0; i < 256; i++) send_exact();
      big_if.in_valid = 1'b0;
      wait_drained();
      chk("busy_after_done", busy, 0);

      // Window 2: one +511 sample, 255 exact
      push_exp(1, 511, 1, 511, 258);
      pulse_start();
      send(16'h00FF, 16'h0100, 17'h003FE);
      for (int i = 1; i < 256; i++) send_exact();
      big_if.in_valid = 1'b0;
      wait_drained();

      // Window 3: every sample 256 below exact
      push_exp(256, 256, 256, -65536, 258);
      pulse_start();
      for (int i = 0; i < 256; i++) send(16'h1000, 16'h0234, 17'h01134);
      big_if.in_valid = 1'b0;
      wait_drained();

      // Reset in the middle of a window, then a clean exact window
      pulse_start();
      for (int i = 0; i < 100; i++) send(16'h1000, 16'h0234, 17'h01000);
      big_if.in_valid = 1'b0;
      rst_n = 1'b0;
      @(posedge clk); #1;
      chk("midrst_mae", mae, 0);
      chk("midrst_max_err", max_err, 0);
      chk("midrst_busy", busy, 0);
      chk("midrst_ready", big_if.in_ready, 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      chk("postrst_err_cnt", err_cnt, 0);
      push_exp(0, 0, 0, 0, 258);
      pulse_start();
      for (int i = 0; i < 256; i++) send_exact();
      big_if.in_valid = 1'b0;
      wait_drained();

      // Back-to-back windows with start held through DONE
      push_exp(3, 3, 256, 768, 258);
      pulse_start();
      for (int i = 0; i < 256; i++) send(W'(i * 37), 16'h0100, {1'b0, W'(i * 37)} + 17'h00103);
      big_if.in_valid = 1'b0;
      start = 1'b1;
      push_exp(0, 0, 0, 0, -1);
      for (int t = 0; t < 10 && !done; t++) begin
         @(posedge clk); #1;
      end
      chk("b2b_done_seen", done, 1);
      @(posedge clk); #1;
      start = 1'b0;
      chk("b2b_busy", busy, 1);
      chk("b2b_ready", big_if.in_ready, 1);
      for (int i = 0; i < 128; i++) send_exact();
      chk("held_mae", mae, 3);
      chk("held_max_err", max_err, 3);
      chk("held_err_cnt", err_cnt, 256);
      for (int i = 128; i < 256; i++) send_exact();
      big_if.in_valid = 1'b0;
      wait_drained();

      // Small window: valid every other cycle, start pulsed during RUN
      oa[0] = 16'd10;    ob[0] = 16'd20;    oap[0] = 17'd34;
      oa[1] = 16'd100;   ob[1] = 16'd1;     oap[1] = 17'd99;
      oa[2] = 16'd5;     ob[2] = 16'd5;     oap[2] = 17'd10;
      oa[3] = 16'hFFFF;  ob[3] = 16'hFFFF;  oap[3] = 17'h1FFFF;
      oa[4] = 16'd7;     ob[4] = 16'd7;     oap[4] = 17'd0;
      begin
         exp_t e;
         int   k;
         logic acc;
         e.mae = 1; e.mx = 4; e.cnt = 3; e.bias = 3; e.lat = 10; e.s_cyc = cyc + 1;
         exp_s_q.push_back(e);
         start_s = 1'b1;
         @(posedge clk); #1;
         start_s = 1'b0;
         k = 0;
         for (int c = 0; c < 12; c++) begin
            small_if.in_valid = c[0];
            small_if.in_a = oa[k];
            small_if.in_b = ob[k];
            small_if.in_approx = oap[k];
            start_s = (c == 4);
            acc = small_if.in_valid & small_if.in_ready;
            if (c == 9) chk("s_ready_closed", small_if.in_ready, 0);
            @(posedge clk); #1;
            if (acc && k < 4) k++;
         end
         small_if.in_valid = 1'b0;
         start_s = 1'b0;
         chk("s_offers_taken", k, 4);
      end
      wait_drained();
      chk("s_accept_count", acc_small, 4);
      chk("s_idle_busy", busy_s, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end
endmodule
